mem_req_arb_2to1: RTL

- Shares one single-ported test memory between two requesters: port 0 is instruction fetch, port 1 is data.
- Sits between parc_Core's imem/dmem val/rdy interfaces and a single-port memory model.
- Arbitrates requests round-robin and records which port owns each outstanding request in an ID FIFO.
- Routes in-order memory responses back to the owning port.

---
 rtl/mem_req_arb_2to1.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_req_arb_2to1.sv
// mem_req_arb_2to1
// Shares one single-ported memory between two val/rdy requesters: port 0
// (instruction fetch) and port 1 (data). Requests are granted round-robin.
// The owner of each outstanding request goes into a small ID FIFO, and the
// in-order memory responses are routed back to the port named at its head.
//
// Optional build feature: define MEM_REQ_ARB_STATS_EN to add the grant and
// full-stall statistics counters (stat_grant0, stat_grant1, stat_full_cycles).
// Without the macro those ports are absent and the port list ends at err_resp.

module mem_req_arb_2to1 #(
    parameter int p_req_msg_sz      = 67,
    parameter int p_resp_msg_sz     = 35,
    parameter int p_max_outstanding = 4
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req0_val,
    output logic                     req0_rdy,
    input  logic [p_req_msg_sz-1:0]  req0_msg,
    output logic                     resp0_val,
    input  logic                     resp0_rdy,
    output logic [p_resp_msg_sz-1:0] resp0_msg,

    input  logic                     req1_val,
    output logic                     req1_rdy,
    input  logic [p_req_msg_sz-1:0]  req1_msg,
    output logic                     resp1_val,
    input  logic                     resp1_rdy,
    output logic [p_resp_msg_sz-1:0] resp1_msg,

    output logic                     memreq_val,
    input  logic                     memreq_rdy,
    output logic [p_req_msg_sz-1:0]  memreq_msg,
    input  logic                     memresp_val,
    output logic                     memresp_rdy,
    input  logic [p_resp_msg_sz-1:0] memresp_msg,

    output logic                     err_resp
`ifdef MEM_REQ_ARB_STATS_EN
    ,
    output logic [31:0]              stat_grant0,
    output logic [31:0]              stat_grant1,
    output logic [31:0]              stat_full_cycles
`endif
);

    localparam int PTR_W = $clog2(p_max_outstanding);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(p_max_outstanding);

    // Arbitration state: prio names the port that wins a tie next cycle.
    logic                         prio;

    // Owner ID of every outstanding request, oldest at head_ptr.
    logic [p_max_outstanding-1:0] id_fifo;
    logic [PTR_W-1:0]             head_ptr;
    logic [PTR_W-1:0]             tail_ptr;
    logic [PTR_W:0]               count;

    logic full;
    logic empty;
    logic any_req;
    logic grant;
    logic head_id;
    logic memreq_fire;
    logic memresp_fire;

    // Full/empty come from the registered count only, so a response popping
    // in the same cycle never lets an extra request in.
    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign any_req = req0_val | req1_val;

    // Round-robin grant: the favoured port wins if it asks, otherwise the
    // other port. With nobody asking the grant defaults to port 0.
    always_comb begin
        grant = 1'b0;
        if (prio) begin
            if (req1_val) begin
                grant = 1'b1;
            end else begin
                grant = 1'b0;
            end
        end else begin
            if (req0_val) begin
                grant = 1'b0;
            end else if (req1_val) begin
                grant = 1'b1;
            end
        end
    end

    // Request side: forward the granted port, only the granted port sees rdy.
    assign memreq_val  = any_req & ~full;
    assign memreq_msg  = grant ? req1_msg : req0_msg;
    assign req0_rdy    = memreq_rdy & ~full & ~grant;
    assign req1_rdy    = memreq_rdy & ~full &  grant;
    assign memreq_fire = memreq_val & memreq_rdy;

    // Response side: the head ID decides which port the response belongs to,
    // and only that port's rdy can accept it.
    assign head_id      = id_fifo[head_ptr];
    assign resp0_val    = memresp_val & ~empty & ~head_id;
    assign resp1_val    = memresp_val & ~empty &  head_id;
    assign resp0_msg    = memresp_msg;
    assign resp1_msg    = memresp_msg;
    assign memresp_rdy  = ~empty & (head_id ? resp1_rdy : resp0_rdy);
    assign memresp_fire = memresp_val & memresp_rdy;

    // Control state: pointers, occupancy, round-robin priority, sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio     <= 1'b0;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            err_resp <= 1'b0;
        end else begin
            if (memreq_fire) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
                prio     <= ~grant;
            end
            if (memresp_fire) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            case ({memreq_fire, memresp_fire})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            // A response with nothing outstanding means the memory is out of
            // step with the arbiter; remember it until the next reset.
            if (memresp_val && empty) begin
                err_resp <= 1'b1;
            end
        end
    end

    // ID storage is plain data: entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (memreq_fire) begin
            id_fifo[tail_ptr] <= grant;
        end
    end

`ifdef MEM_REQ_ARB_STATS_EN
    // Statistics: per-port grant totals and cycles stalled by a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grant0      <= '0;
            stat_grant1      <= '0;
            stat_full_cycles <= '0;
        end else begin
            if (memreq_fire && !grant) begin
                stat_grant0 <= stat_grant0 + 32'd1;
            end
            if (memreq_fire && grant) begin
                stat_grant1 <= stat_grant1 + 32'd1;
            end
            if (full && any_req) begin
                stat_full_cycles <= stat_full_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
